flag_branch_unit: RTL
=====================

Name: flag_branch_unit

Overview:
- Consumer end of the ALU flag interface. Holds the architectural flag register {Z,V,N}.
- Merges ALU flag results using a per-opcode update mask.
- Tracks flag-setting ops still in flight between issue and EX writeback.
- Resolves conditional branches against up-to-date flags, stalling the branch handshake until no flag write is pending.
- Sits between EX (flag producer) and the fetch/PC-select logic (branch consumer).

Parameters:
- PEND_MAX, 3, maximum outstanding flag-setting ops tracked.
- CNT_W, 2, width of the pending counter; must satisfy 2^CNT_W > PEND_MAX.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flag_issue  in  1  a flag-setting op enters EX this cycle.
- issue_ready  out  1  comb: pend_cnt < PEND_MAX.
- flag_wr  in  1  EX flag result valid this cycle.
- alu_op  in  3  opcode of the op writing flags: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB.
- alu_flags  in  3  {Z,V,N} from the ALU.
- flags  out  3  current registered {Z,V,N}.
- pend_cnt  out  CNT_W  outstanding flag writers.
- br_valid  in  1  branch request.
- br_ccc  in  3  condition code.
- br_ready  out  1  comb: 1 only in state IDLE.
- br_taken  out  1  registered resolution, valid when br_done=1.
- br_done  out  1  registered one-cycle pulse.

Behaviour:

Reset (async, immediate):
- flags=000, pend_cnt=0, state=IDLE, br_taken=0, br_done=0.
- br_ready=1 as soon as rst deasserts.

Update mask, applied on flag_wr:
- op 0/1 write Z,V,N.
- op 2/4/5/6 write Z only.
- op 3/7 write nothing.
- Unmasked bits hold.

Bypass flags (comb):
- bflags = merge(flags, alu_flags, mask) when flag_wr=1, else flags.

Pending counter:
- flag_issue alone (and issue_ready): +1.
- flag_wr alone: -1, saturating at 0. Underflow still updates flags; counter stays 0.
- Both in the same cycle: unchanged.
- flag_issue when cnt==PEND_MAX: ignored (no increment). The upstream stage is required to honour issue_ready.

Clear condition:
- clear = (pend_cnt==0) OR (pend_cnt==1 AND flag_wr AND NOT flag_issue).
- clear is evaluated on the current-cycle counter and inputs.

Conditions, evaluated on bflags:
- 000 NE: Z=0.
- 001 EQ: Z=1.
- 010 GT: Z=0 and N=0.
- 011 LT: N=1.
- 100 GE: Z=1 or (Z=0 and N=0).
- 101 LE: N=1 or Z=1.
- 110 OV: V=1.
- 111 UN: always.

FSM (IDLE, WAIT):
- IDLE, br_valid=1 (accepted since br_ready=1):
  - If clear: next cycle br_done=1 and br_taken=cond(br_ccc, bflags); stay IDLE.
  - Else: latch br_ccc into ccc_q; go WAIT.
- WAIT: br_ready=0; br_valid ignored.
  - When clear: next cycle br_done=1, br_taken=cond(ccc_q, bflags); go IDLE.
- br_done is high exactly one cycle per accepted branch.
- br_taken holds its value until the next br_done.
- Back-to-back branches: a branch may be accepted in the cycle br_done is high. Steady-state throughput is one branch per cycle.
- flag_issue in the same cycle a branch is accepted counts as younger than the branch: it does not block that branch when clear holds.
- Reset mid-WAIT: return to IDLE, ccc_q discarded, no br_done pulse.

Latency:
- Flag register update: 1 cycle.
- Branch resolution: 1 cycle after acceptance, or 1 cycle after the clearing flag_wr.

Test Plan:
- Reset, then ADD write alu_flags=101 -> flags=101. Then XOR write alu_flags=010 -> flags=001 (Z from XOR, V,N held).
- RED write alu_flags=111 with flags=000 -> flags stay 000. pend_cnt unchanged from 0 (underflow saturates).
- flags=000, cnt=0, br_valid with ccc=010 (GT) -> br_done=1, br_taken=1 next cycle. Same stimulus with ccc=001 -> br_taken=0.
- flag_issue x2 (cnt=2), br_valid ccc=001 -> br_ready=0, state WAIT.
  - flag_wr SUB Z=0 -> cnt=1, no br_done.
  - flag_wr SUB alu_flags=100 -> br_done next cycle with br_taken=1, flags=100.
- cnt=3 -> issue_ready=0; extra flag_issue leaves cnt=3. flag_issue and flag_wr in the same cycle -> cnt unchanged.
- In WAIT, assert rst -> state IDLE, br_done never pulses, flags=000. Next br_valid with ccc=111 -> br_taken=1.

Source files
------------

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : Architectural {Z,V,N} flag register with per-opcode update
//               mask, in-flight flag-writer tracking and conditional branch
//               resolution that waits until no flag write is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit #(
    parameter int PEND_MAX = 3,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_issue,
    output logic             issue_ready,
    input  logic             flag_wr,
    input  logic [2:0]       alu_op,
    input  logic [2:0]       alu_flags,
    output logic [2:0]       flags,
    output logic [CNT_W-1:0] pend_cnt,
    input  logic             br_valid,
    input  logic [2:0]       br_ccc,
    output logic             br_ready,
    output logic             br_taken,
    output logic             br_done
);

    localparam logic [CNT_W-1:0] c_PEND_MAX = CNT_W'(PEND_MAX);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_flags;
    logic [2:0]       r_ccc_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_br_taken;
    logic             r_br_done;

    logic [2:0]       w_mask;
    logic [2:0]       w_bflags;
    logic             w_inc;
    logic             w_clear;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Resolve a condition code against a {Z,V,N} flag vector.
    function automatic logic f_cond(input logic [2:0] ccc, input logic [2:0] f);
        logic z;
        logic v;
        logic n;
        logic res;
        z = f[2];
        v = f[1];
        n = f[0];
        case (ccc)
            3'd0:    res = ~z;
            3'd1:    res = z;
            3'd2:    res = ~z & ~n;
            3'd3:    res = n;
            3'd4:    res = z | ~n;
            3'd5:    res = n | z;
            3'd6:    res = v;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // Per-opcode flag write mask: arithmetic writes all, logic/shift write Z.
    always_comb begin
        w_mask = 3'b000;
        case (alu_op)
            3'd0, 3'd1:             w_mask = 3'b111;
            3'd2, 3'd4, 3'd5, 3'd6: w_mask = 3'b100;
            default:                w_mask = 3'b000;
        endcase
    end

    // Bypassed flags, so a branch sees this cycle's EX flag result.
    assign w_bflags = flag_wr ? ((r_flags & ~w_mask) | (alu_flags & w_mask)) : r_flags;

    assign issue_ready = (r_cnt < c_PEND_MAX);
    assign w_inc       = flag_issue & issue_ready;

    // A same-cycle issue is younger than any branch seen now, so it is
    // excluded from the clear test.
    assign w_clear = (r_cnt == '0) || ((r_cnt == c_ONE) && flag_wr && !flag_issue);

    // Outstanding-writer count: issue and writeback together cancel out.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_inc && !flag_wr) begin
            w_cnt_nxt = r_cnt + c_ONE;
        end else if (flag_wr && !w_inc && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - c_ONE;
        end
    end

    // Flag register and pending counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 3'b000;
            r_cnt   <= '0;
        end else begin
            r_flags <= w_bflags;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Branch FSM: resolve immediately when clear, otherwise park in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ccc_q    <= 3'b000;
            r_br_taken <= 1'b0;
            r_br_done  <= 1'b0;
        end else begin
            r_br_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (br_valid) begin
                        if (w_clear) begin
                            r_br_done  <= 1'b1;
                            r_br_taken <= f_cond(br_ccc, w_bflags);
                        end else begin
                            r_ccc_q <= br_ccc;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_clear) begin
                        r_br_done  <= 1'b1;
                        r_br_taken <= f_cond(r_ccc_q, w_bflags);
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign flags    = r_flags;
    assign pend_cnt = r_cnt;
    assign br_ready = (r_state == S_IDLE);
    assign br_taken = r_br_taken;
    assign br_done  = r_br_done;

endmodule
`default_nettype wire
